// File: rtl/iter_muldiv_alu.sv
// Iterative MUL/DIV unit owning HI/LO; optional MULDIV_EARLY_OUT_EN skips zero-operand ops.
// Latency: WIDTH/MUL_STEP+1 (MUL) or WIDTH+1 (DIV) busy cycles, done pulses the cycle after.
// Backpressure: busy stalls EX; start is only sampled while idle and is never queued.
`ifndef FUNC_MUL
`define FUNC_MUL 5'h18
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'h1A
`endif

module iter_muldiv_alu #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       func,
    input  logic             sign,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_write,
    input  logic [WIDTH-1:0] hi_write_data,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] lo_write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW        = $clog2(WIDTH) + 1;
    localparam int MUL_ITERS = WIDTH / MUL_STEP;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_opa;
    logic [WIDTH-1:0]       r_src_a;
    logic [CW-1:0]          r_cnt;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_div0;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_done;

    logic                   w_is_mul;
    logic                   w_is_div;
    logic                   w_accept;
    logic                   w_early;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH+MUL_STEP-1:0] w_pp;
    logic [WIDTH+MUL_STEP-1:0] w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_nxt;
    logic [WIDTH:0]         w_div_trial;
    logic [2*WIDTH-1:0]     w_div_nxt;
    logic [WIDTH-1:0]       w_res_hi;
    logic [WIDTH-1:0]       w_res_lo;

    assign w_is_mul = (func == `FUNC_MUL);
    assign w_is_div = (func == `FUNC_DIV);
    assign w_accept = start && (r_state == S_IDLE) && !flush && (w_is_mul || w_is_div);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = (src_a == '0) || (src_b == '0);
`else
    assign w_early = 1'b0;
`endif

    // Iterate on magnitudes; signs are reapplied in FIX.
    assign w_neg_a = sign && src_a[WIDTH-1];
    assign w_neg_b = sign && src_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -src_a : src_a;
    assign w_mag_b = w_neg_b ? -src_b : src_b;

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_early) begin
                        w_state_nxt = S_FIX;
                    end else if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL:   if (r_cnt == CW'(MUL_ITERS - 1)) w_state_nxt = S_FIX;
            S_DIV:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Shift-add: low MUL_STEP multiplier bits select partial products added into the top half.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_acc[j]) begin
                w_pp = w_pp + ({{MUL_STEP{1'b0}}, r_opa} << j);
            end
        end
        w_mul_sum = {{MUL_STEP{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;
        w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:MUL_STEP]};
    end

    // Restoring divide: the trial MSB is the borrow, clear means the divisor fits.
    always_comb begin
        w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opa};
        if (!w_div_trial[WIDTH]) begin
            w_div_nxt = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc    <= '0;
            r_opa    <= '0;
            r_src_a  <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_src_a  <= src_a;
            r_is_div <= w_is_div;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_div0   <= w_is_div && (src_b == '0);
            if (w_early) begin
                r_acc <= '0;
                r_opa <= '0;
            end else if (w_is_mul) begin
                r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                r_opa <= w_mag_a;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                r_opa <= w_mag_b;
            end
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_nxt;
            r_cnt <= r_cnt + CW'(1);
        end else if (r_state == S_DIV) begin
            r_acc <= w_div_nxt;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_res_hi = r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_acc[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_res_hi = r_src_a;
                w_res_lo = '1;
            end else begin
                if (r_neg_r) w_res_hi = -r_acc[2*WIDTH-1:WIDTH];
                if (r_neg_q) w_res_lo = -r_acc[WIDTH-1:0];
            end
        end else if (r_neg_q) begin
            {w_res_hi, w_res_lo} = -r_acc;
        end
    end

    // Completion beats MTHI/MTLO on the same edge; flush blocks both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                if (r_state == S_FIX) begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end else begin
                    if (hi_write) r_hi <= hi_write_data;
                    if (lo_write) r_lo <= lo_write_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Bench for iter_muldiv_alu: literal directed cases plus random traffic against a cycle-level model.
`ifndef FUNC_MUL
`define FUNC_MUL 5'h18
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'h1A
`endif

module tb_iter_muldiv_alu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [4:0]  func;
    logic        sign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_write;
    logic [31:0] hi_write_data;
    logic        lo_write;
    logic [31:0] lo_write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    int          m_left;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_res;

    iter_muldiv_alu #(.WIDTH(32), .MUL_STEP(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .func(func), .sign(sign),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi_write(hi_write), .hi_write_data(hi_write_data),
        .lo_write(lo_write), .lo_write_data(lo_write_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [4:0] f, input logic s,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        if (f == `FUNC_MUL) begin
            if (s) begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int op_lat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return (f == `FUNC_MUL) ? 17 : 33;
    endfunction

    // Model: m_left counts busy cycles still to run; 0 means idle.
    initial begin
        m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_res = '0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
            end else begin
                m_done = 1'b0;
                if (flush) begin
                    m_left = 0;
                end else if (m_left == 1) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                    m_left = 0;
                end else begin
                    if (hi_write) m_hi = hi_write_data;
                    if (lo_write) m_lo = lo_write_data;
                    if (m_left > 1) begin
                        m_left--;
                    end else if (start && (func == `FUNC_MUL || func == `FUNC_DIV)) begin
                        m_res  = model_res(func, sign, src_a, src_b);
                        m_left = op_lat(func, src_a, src_b);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_busy", {31'b0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic launch(input logic [4:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        func = f; sign = s; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_done(input string name, input int already, input int lat,
                             input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        n = already;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check({name, "_lat"}, n, lat);
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        resetn = 1'b0; start = 1'b0; func = 5'd0; sign = 1'b0; src_a = '0; src_b = '0;
        flush = 1'b0; hi_write = 1'b0; hi_write_data = '0; lo_write = 1'b0; lo_write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        launch(`FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("umul_max", 0, 17, 32'hFFFF_FFFE, 32'h0000_0001);
        launch(`FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("sdiv_m7_2", 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch(`FUNC_DIV, 1'b0, 32'd7, 32'd0);
        wait_done("udiv_7_0", 0, op_lat(`FUNC_DIV, 32'd7, 32'd0), 32'd7, 32'hFFFF_FFFF);
        launch(`FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("sdiv_min_m1", 0, 33, 32'd0, 32'h8000_0000);
        launch(`FUNC_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_done("smul_m3_5", 0, 17, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Kill a divide in its fifth busy cycle.
        launch(`FUNC_DIV, 1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        check("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_hi", hi, 32'hFFFF_FFFF);
        check("flush_lo", lo, 32'hFFFF_FFF1);
        @(posedge clk); #1;
        check("flush_done2", {31'b0, done}, 32'd0);
        launch(`FUNC_MUL, 1'b0, 32'd6, 32'd7);
        wait_done("post_flush", 0, 17, 32'd0, 32'd42);

        // MTLO mid-multiply, then ignored start pulses.
        launch(`FUNC_MUL, 1'b0, 32'h0001_0000, 32'h0003_0003);
        lo_write = 1'b1; lo_write_data = 32'h0000_1234;
        @(posedge clk); #1;
        lo_write = 1'b0;
        check("mtlo_busy_lo", lo, 32'h0000_1234);
        check("mtlo_busy_hi", hi, 32'd0);
        func = `FUNC_DIV; sign = 1'b0; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_done("mtlo_mul", 4, 17, 32'd3, 32'h0003_0000);
        @(posedge clk); #1;
        check("ign_start_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a multiply.
        launch(`FUNC_MUL, 1'b1, 32'd123, 32'hFFFF_FE38);
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check("amid_rst_busy", {31'b0, busy}, 32'd0);
        check("amid_rst_hi", hi, 32'd0);
        check("amid_rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

`ifdef MULDIV_EARLY_OUT_EN
        launch(`FUNC_MUL, 1'b0, 32'd0, 32'd9);
        wait_done("early_mul0", 0, 1, 32'd0, 32'd0);
`endif

        for (int c = 0; c < 4000; c++) begin
            start         = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0, 1, 2: func = `FUNC_MUL;
                3, 4, 5: func = `FUNC_DIV;
                default: func = 5'($urandom);
            endcase
            sign          = 1'($urandom);
            src_a         = rand_opnd();
            src_b         = rand_opnd();
            flush         = ($urandom_range(0, 99) == 0);
            hi_write      = ($urandom_range(0, 7) == 0);
            lo_write      = ($urandom_range(0, 7) == 0);
            hi_write_data = $urandom;
            lo_write_data = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("drain_idle", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
